// File: rtl/control_flow_pkg.sv
// Shared definitions for the read/write burst flow controller.
//   flow_state_e : 3-bit controller state encoding
//   STATE_W      : state register width
//   tmo_cnt_w()  : width of the transfer timeout counter for a given limit
package control_flow_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE          = 3'd0,
        READ_MEMORY   = 3'd1,
        SAMPLE_DATA   = 3'd2,
        TRANSFER_DATA = 3'd3,
        WRITE_MEMORY  = 3'd4
    } flow_state_e;

    // A limit of 0 disables the timeout; keep the counter at least 1 bit wide.
    function automatic int tmo_cnt_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/flow_timeout_counter.sv
// Cycle counter that watches how long a transfer beat has been outstanding.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   clear   : zero the count (wins over enable)
//   enable  : count this cycle
//   expire  : count has reached TIMEOUT_CYC-1 (never asserted when TIMEOUT_CYC=0)
module flow_timeout_counter
    import control_flow_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (TIMEOUT_CYC != 0) && (cnt_q == LAST);

    // Saturate once expired so a disabled or ignored expiry never wraps back.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != LAST))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/control_rw_burst_flow.sv
// Read/write burst flow controller. Accepts a command from the decoder and
// sequences memory access, data sampling and serial transfer for each beat
// of a burst with an auto-incrementing address.
//   Clk, Reset          : clock, synchronous active-high reset
//   ValidCmd/RW/Mode    : command valid, 1=write, 1=memory mode
//   Active              : channel enable; low aborts any operation
//   TransferDone        : transfer datapath finished the current beat
//   BaseAddr, BurstLen  : start address and beat count (0 means 1)
//   AccessMem/RWMem/SampleData/TransferData/Busy : state decodes
//   MemAddr             : current beat address
//   CmdDone/Abort/Timeout : one-cycle completion pulses
module control_rw_burst_flow
    import control_flow_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BURST_W     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ValidCmd,
    input  logic              RW,
    input  logic              Mode,
    input  logic              Active,
    input  logic              TransferDone,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [BURST_W-1:0] BurstLen,
    output logic              AccessMem,
    output logic              RWMem,
    output logic              SampleData,
    output logic              TransferData,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              CmdDone,
    output logic              Abort,
    output logic              Timeout
);

    localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

    flow_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               tmo_q, tmo_d;
    logic               tmo_expire;

    assign AccessMem    = (state_q == READ_MEMORY) || (state_q == WRITE_MEMORY);
    assign RWMem        = (state_q == WRITE_MEMORY);
    assign SampleData   = (state_q == SAMPLE_DATA);
    assign TransferData = (state_q == TRANSFER_DATA);
    assign Busy         = (state_q != IDLE);
    assign MemAddr      = addr_q;
    assign CmdDone      = done_q;
    assign Abort        = abort_q;
    assign Timeout      = tmo_q;

    // Count is zeroed while sampling so every beat's transfer starts at 0.
    flow_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (state_q == SAMPLE_DATA),
        .enable ((state_q == TRANSFER_DATA) && !TransferDone),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ValidCmd && Active) begin
                    if (Mode && RW)
                        state_d = WRITE_MEMORY;
                    else if (Mode && !TransferDone)
                        state_d = READ_MEMORY;
                    else if (!Mode && !TransferDone)
                        state_d = SAMPLE_DATA;
                end
                if (state_d != IDLE) begin
                    addr_d  = BaseAddr;
                    beats_d = (BurstLen == '0) ? ONE_BEAT : BurstLen;
                    mode_d  = Mode;
                end
            end

            READ_MEMORY: begin
                if (!Active) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = SAMPLE_DATA;
                end
            end

            SAMPLE_DATA: begin
                if (!Active) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = TRANSFER_DATA;
                end
            end

            // Priority: Active drop, then beat completion, then timeout.
            TRANSFER_DATA: begin
                if (!Active) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (TransferDone) begin
                    beats_d = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = mode_q ? READ_MEMORY : SAMPLE_DATA;
                    end
                end else if (tmo_expire) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end

            // The last beat completes even if the command is withdrawn on it.
            WRITE_MEMORY: begin
                if (!Active) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (beats_q == ONE_BEAT) begin
                    beats_d = beats_q - ONE_BEAT;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (!ValidCmd || !RW) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    beats_d = beats_q - ONE_BEAT;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_control_rw_burst_flow.sv
// Cycle-accurate bench: each scenario queues per-cycle stimulus together with
// the expected state decode, pulses and address, then replays the queue.
module tb_control_rw_burst_flow;

    logic       Clk = 1'b0;
    logic       Reset, ValidCmd, RW, Mode, Active, TransferDone;
    logic [7:0] BaseAddr;
    logic [3:0] BurstLen;
    logic       AccessMem, RWMem, SampleData, TransferData, Busy;
    logic [7:0] MemAddr;
    logic       CmdDone, Abort, Timeout;

    always #5 Clk = ~Clk;

    control_rw_burst_flow #(.ADDR_W(8), .BURST_W(4), .TIMEOUT_CYC(8)) dut (
        .Clk(Clk), .Reset(Reset), .ValidCmd(ValidCmd), .RW(RW), .Mode(Mode),
        .Active(Active), .TransferDone(TransferDone), .BaseAddr(BaseAddr),
        .BurstLen(BurstLen), .AccessMem(AccessMem), .RWMem(RWMem),
        .SampleData(SampleData), .TransferData(TransferData), .Busy(Busy),
        .MemAddr(MemAddr), .CmdDone(CmdDone), .Abort(Abort), .Timeout(Timeout)
    );

    typedef struct packed {
        logic rst, v, rw, mode, act, td;
        logic [7:0] base;
        logic [3:0] blen;
    } stim_t;

    typedef struct packed {
        logic [4:0] st;   // {AccessMem, RWMem, SampleData, TransferData, Busy}
        logic [2:0] p;    // {CmdDone, Abort, Timeout}
        logic       ca;   // compare MemAddr this cycle
        logic [7:0] addr;
    } exp_t;

    localparam logic [4:0] S_ID = 5'b00000, S_RD = 5'b10001, S_SM = 5'b00101,
                           S_XF = 5'b00011, S_WR = 5'b11001;
    localparam logic [2:0] P_NO = 3'b000, P_DN = 3'b100, P_AB = 3'b010, P_TO = 3'b001;

    stim_t sq[$];
    exp_t  sb[$];
    int    n_chk = 0;
    int    n_pass = 0;

    logic [4:0] obs_st;
    logic [2:0] obs_p;
    assign obs_st = {AccessMem, RWMem, SampleData, TransferData, Busy};
    assign obs_p  = {CmdDone, Abort, Timeout};

    function automatic stim_t ms(input logic rst, input logic v, input logic rw,
                                 input logic mode, input logic act, input logic td,
                                 input logic [7:0] base, input logic [3:0] blen);
        stim_t s;
        s.rst = rst; s.v = v; s.rw = rw; s.mode = mode; s.act = act; s.td = td;
        s.base = base; s.blen = blen;
        return s;
    endfunction

    function automatic exp_t me(input logic [4:0] st, input logic [2:0] p,
                                input logic ca, input logic [7:0] addr);
        exp_t e;
        e.st = st; e.p = p; e.ca = ca; e.addr = addr;
        return e;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        sq.push_back(s);
        sb.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        Reset = s.rst; ValidCmd = s.v; RW = s.rw; Mode = s.mode;
        Active = s.act; TransferDone = s.td; BaseAddr = s.base; BurstLen = s.blen;
    endtask

    task automatic test_reset();
        stim_t s; exp_t e;
        for (int i = 0; i < 3; i++)
            add(ms(1, 1, 0, 1, 1, 0, 8'hAA, 4'd3), me(S_ID, P_NO, 1, 8'h00));
        add(ms(0, 0, 0, 1, 1, 0, 8'hAA, 4'd3), me(S_ID, P_NO, 1, 8'h00));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL reset c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_read_burst();
        stim_t s; exp_t e;
        logic [7:0] a;
        add(ms(0, 1, 0, 1, 1, 0, 8'hFE, 4'd3), me(S_RD, P_NO, 1, 8'hFE));
        for (int b = 0; b < 3; b++) begin
            a = 8'hFE + 8'(b);
            if (b > 0) add(ms(0, 0, 0, 1, 1, 1, 8'hFE, 4'd3), me(S_RD, P_NO, 1, a));
            add(ms(0, 0, 0, 1, 1, 0, 8'hFE, 4'd3), me(S_SM, P_NO, 1, a));
            add(ms(0, 0, 0, 1, 1, 0, 8'hFE, 4'd3), me(S_XF, P_NO, 1, a));
            add(ms(0, 0, 0, 1, 1, 0, 8'hFE, 4'd3), me(S_XF, P_NO, 1, a));
        end
        add(ms(0, 0, 0, 1, 1, 1, 8'hFE, 4'd3), me(S_ID, P_DN, 0, 8'h00));
        add(ms(0, 0, 0, 1, 1, 0, 8'hFE, 4'd3), me(S_ID, P_NO, 0, 8'h00));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL read c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_write_burst();
        stim_t s; exp_t e;
        for (int i = 0; i < 4; i++)
            add(ms(0, 1, 1, 1, 1, 0, 8'h10, 4'd4), me(S_WR, P_NO, 1, 8'h10 + 8'(i)));
        add(ms(0, 0, 1, 1, 1, 0, 8'h10, 4'd4), me(S_ID, P_DN, 0, 8'h00));
        add(ms(0, 0, 1, 1, 1, 0, 8'h10, 4'd4), me(S_ID, P_NO, 0, 8'h00));
        // RW withdrawn on the second beat
        add(ms(0, 1, 1, 1, 1, 0, 8'h10, 4'd4), me(S_WR, P_NO, 1, 8'h10));
        add(ms(0, 1, 1, 1, 1, 0, 8'h10, 4'd4), me(S_WR, P_NO, 1, 8'h11));
        add(ms(0, 1, 0, 1, 1, 0, 8'h10, 4'd4), me(S_ID, P_AB, 1, 8'h11));
        add(ms(0, 0, 0, 1, 1, 0, 8'h10, 4'd4), me(S_ID, P_NO, 1, 8'h11));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL write c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_sample_mode();
        stim_t s; exp_t e;
        add(ms(0, 1, 0, 0, 1, 0, 8'h40, 4'd0), me(S_SM, P_NO, 1, 8'h40));
        add(ms(0, 0, 0, 0, 1, 0, 8'h40, 4'd0), me(S_XF, P_NO, 1, 8'h40));
        add(ms(0, 0, 0, 0, 1, 1, 8'h40, 4'd0), me(S_ID, P_DN, 0, 8'h00));
        add(ms(0, 0, 0, 0, 1, 0, 8'h40, 4'd0), me(S_ID, P_NO, 0, 8'h00));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL sample c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        stim_t s; exp_t e;
        // Run 0: TransferDone never comes. Run 1: it arrives in the 8th cycle.
        for (int r = 0; r < 2; r++) begin
            add(ms(0, 1, 0, 1, 1, 0, 8'h20, 4'd1), me(S_RD, P_NO, 1, 8'h20));
            add(ms(0, 0, 0, 1, 1, 0, 8'h20, 4'd1), me(S_SM, P_NO, 1, 8'h20));
            add(ms(0, 0, 0, 1, 1, 0, 8'h20, 4'd1), me(S_XF, P_NO, 1, 8'h20));
            for (int i = 0; i < 7; i++)
                add(ms(0, 0, 0, 1, 1, 0, 8'h20, 4'd1), me(S_XF, P_NO, 1, 8'h20));
            add(ms(0, 0, 0, 1, 1, r[0], 8'h20, 4'd1), me(S_ID, (r == 0) ? P_TO : P_DN, 0, 8'h00));
            add(ms(0, 0, 0, 1, 1, 0, 8'h20, 4'd1), me(S_ID, P_NO, 0, 8'h00));
        end
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL timeout c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_abort_transfer();
        stim_t s; exp_t e;
        add(ms(0, 1, 0, 1, 1, 0, 8'h30, 4'd2), me(S_RD, P_NO, 1, 8'h30));
        add(ms(0, 0, 0, 1, 1, 0, 8'h30, 4'd2), me(S_SM, P_NO, 1, 8'h30));
        add(ms(0, 0, 0, 1, 1, 0, 8'h30, 4'd2), me(S_XF, P_NO, 1, 8'h30));
        add(ms(0, 0, 0, 1, 0, 1, 8'h30, 4'd2), me(S_ID, P_AB, 1, 8'h30));
        add(ms(0, 0, 0, 1, 1, 0, 8'h30, 4'd2), me(S_ID, P_NO, 1, 8'h30));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL abort c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        stim_t s; exp_t e;
        add(ms(0, 1, 1, 1, 1, 0, 8'h50, 4'd5), me(S_WR, P_NO, 1, 8'h50));
        add(ms(0, 1, 1, 1, 1, 0, 8'h50, 4'd5), me(S_WR, P_NO, 1, 8'h51));
        add(ms(1, 1, 1, 1, 1, 0, 8'h50, 4'd5), me(S_ID, P_NO, 1, 8'h00));
        add(ms(0, 0, 1, 1, 1, 0, 8'h50, 4'd5), me(S_ID, P_NO, 1, 8'h00));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL rst_mid c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; exp_t e;
        // ValidCmd held high: the second command is taken after one idle cycle.
        add(ms(0, 1, 0, 0, 1, 0, 8'h60, 4'd1), me(S_SM, P_NO, 1, 8'h60));
        add(ms(0, 1, 0, 0, 1, 0, 8'h60, 4'd1), me(S_XF, P_NO, 1, 8'h60));
        add(ms(0, 1, 0, 0, 1, 1, 8'h70, 4'd1), me(S_ID, P_DN, 0, 8'h00));
        add(ms(0, 1, 0, 0, 1, 0, 8'h70, 4'd1), me(S_SM, P_NO, 1, 8'h70));
        add(ms(0, 0, 0, 0, 1, 0, 8'h70, 4'd1), me(S_XF, P_NO, 1, 8'h70));
        add(ms(0, 0, 0, 0, 1, 1, 8'h70, 4'd1), me(S_ID, P_DN, 0, 8'h00));
        add(ms(0, 0, 0, 0, 1, 0, 8'h70, 4'd1), me(S_ID, P_NO, 0, 8'h00));
        for (int k = 0; sq.size() > 0; k++) begin
            s = sq.pop_front(); apply(s); @(posedge Clk); #1; e = sb.pop_front(); n_chk++;
            if (obs_st !== e.st || obs_p !== e.p || (e.ca && MemAddr !== e.addr))
                $display("FAIL b2b c%0d: got st=%b p=%b addr=%h, want st=%b p=%b addr=%h",
                         k, obs_st, obs_p, MemAddr, e.st, e.p, e.addr);
            else n_pass++;
        end
    endtask

    initial begin
        apply(ms(1, 0, 0, 0, 0, 0, 8'h00, 4'd0));
        test_reset();
        test_read_burst();
        test_write_burst();
        test_sample_mode();
        test_timeout();
        test_abort_transfer();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/control_rw_burst_flow.md
Name: control_rw_burst_flow

Overview:
Parametrised second-generation read/write flow controller. It sequences memory access, data sampling and serial transfer for multi-beat bursts with an auto-incrementing address. It adds transfer timeout, abort reporting and command-done pulses. It sits between the command decoder (ValidCmd/RW/Mode/Active) and the memory plus transfer datapath.

Parameters:
ADDR_W, 8, width of BaseAddr/MemAddr; address wraps modulo 2^ADDR_W
BURST_W, 4, width of BurstLen; max burst = 2^BURST_W-1 beats
TIMEOUT_CYC, 255, max cycles in TRANSFER_DATA without TransferDone; 0 disables timeout

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
ValidCmd  in  1  command valid
RW  in  1  1=write, 0=read
Mode  in  1  1=memory mode, 0=sample-only mode
Active  in  1  channel enable; low aborts any operation
TransferDone  in  1  transfer datapath finished current beat
BaseAddr  in  ADDR_W  start address, captured at command accept
BurstLen  in  BURST_W  beat count, captured at accept; 0 treated as 1
AccessMem  out  1  high in READ_MEMORY or WRITE_MEMORY
RWMem  out  1  high in WRITE_MEMORY
SampleData  out  1  high in SAMPLE_DATA
TransferData  out  1  high in TRANSFER_DATA
Busy  out  1  high in any state except IDLE
MemAddr  out  ADDR_W  current beat address
CmdDone  out  1  1-cycle pulse: burst completed normally
Abort  out  1  1-cycle pulse: Active/ValidCmd/RW dropped mid-burst
Timeout  out  1  1-cycle pulse: transfer timeout hit

Behaviour:
- States: IDLE, READ_MEMORY, SAMPLE_DATA, TRANSFER_DATA, WRITE_MEMORY; 3-bit encoding.
- AccessMem, RWMem, SampleData, TransferData and Busy are Moore decodes of the state register. MemAddr, CmdDone, Abort and Timeout are registered.
- Reset (sync, wins over all inputs): state=IDLE; MemAddr=0; beat and timeout counters=0; all outputs 0.
- Command accept happens in IDLE only, when ValidCmd && Active:
  - Mode && !RW && !TransferDone -> READ_MEMORY.
  - Mode && RW -> WRITE_MEMORY.
  - !Mode && !TransferDone -> SAMPLE_DATA.
  - Otherwise the controller stays in IDLE.
  - On accept: MemAddr<=BaseAddr; beats_left<=max(BurstLen,1).
- Latency: ValidCmd sampled at edge n -> decoded output high in cycle n+1.
- READ_MEMORY: 1 cycle, then SAMPLE_DATA.
- SAMPLE_DATA: 1 cycle, then TRANSFER_DATA. Timeout counter cleared on entry.
- TRANSFER_DATA:
  - Stays while !TransferDone.
  - On TransferDone, beats_left decrements.
  - If beats_left was 1 -> IDLE with CmdDone.
  - Else MemAddr<=MemAddr+1 (wraps) and next state is READ_MEMORY (Mode=1 at accept) or SAMPLE_DATA (Mode=0 at accept).
  - Mode is latched at accept; later Mode changes are ignored.
- Timeout: the counter increments each TRANSFER_DATA cycle without TransferDone. When it reaches TIMEOUT_CYC-1 and TransferDone is still low -> IDLE with Timeout pulse. TransferDone in that same cycle wins (normal completion).
- WRITE_MEMORY: one beat per cycle. Each cycle, MemAddr increments and beats_left decrements. When beats_left reaches 1 -> IDLE with CmdDone. If ValidCmd, RW or Active drops before the last beat -> IDLE with Abort; no address increment on that cycle.
- Active low in any non-IDLE state -> IDLE next cycle with Abort. This takes priority over TransferDone and timeout. Only one of CmdDone/Abort/Timeout is asserted per cycle.
- No implicit latches: every state has a defined next state (SAMPLE_DATA with Active low -> IDLE).
- Reset mid-burst: IDLE next edge; no CmdDone/Abort/Timeout pulse.
- Back-to-back commands: the earliest accept is the cycle after returning to IDLE; Busy is low for at least 1 cycle.

Decomposition:
- Package control_flow_pkg: state localparams (IDLE..WRITE_MEMORY, 3-bit), state width constant, timeout counter width via $clog2(TIMEOUT_CYC+1).
- Sub-module flow_timeout_counter: clear, enable, TIMEOUT_CYC parameter, expire output. Its reset follows the same sync active-high rule.

Test Plan:
- Reset held 3 cycles with ValidCmd=1 -> all outputs 0, MemAddr=0, Busy=0 throughout.
- Read burst, Mode=1 RW=0 BaseAddr=0xFE BurstLen=3, TransferDone after 2 TRANSFER cycles per beat -> MemAddr 0xFE, 0xFF, 0x00 (wrap); 3×(READ, SAMPLE, TRANSFER); single CmdDone pulse; Busy drops the cycle after.
- Write burst, RW=1 BurstLen=4 BaseAddr=0x10 -> AccessMem=RWMem=1 for 4 cycles, MemAddr 0x10–0x13, CmdDone. Repeat with RW dropped on beat 2 -> Abort pulse, IDLE, MemAddr=0x11.
- Sample mode, Mode=0 BurstLen=0 -> treated as 1 beat: SAMPLE then TRANSFER, AccessMem never high, CmdDone on TransferDone.
- Timeout: TIMEOUT_CYC=8, TransferDone never asserted -> 8 TRANSFER cycles, then Timeout pulse, IDLE. TransferDone in cycle 8 -> CmdDone instead of Timeout.
- Active dropped in TRANSFER_DATA in the same cycle as TransferDone -> Abort only, IDLE, no CmdDone.
